// File: rtl/nmk112_pkg.sv
// Shared types, address-map boundaries and address helpers for the NMK112 bank mapper.
package nmk112_pkg;

    typedef enum logic [1:0] {
        TABLE_PAGE = 2'd0,
        TABLE_HI   = 2'd1,
        BANKED     = 2'd2
    } region_e;

    localparam logic [17:0] TABLE_PAGE_MAX = 18'h003FF;
    localparam logic [17:0] TABLE_HI_MIN   = 18'h00400;
    localparam logic [17:0] BANKED_MIN     = 18'h10000;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Sum is built wide so oversized bank values wrap instead of saturating.
    function automatic logic [63:0] wrap_rom_addr(
        input logic [31:0] bank,
        input logic [31:0] offset,
        input int          bank_log2,
        input int          rom_aw,
        input logic [63:0] rom_offs
    );
        logic [63:0] rom_mask;
        logic [63:0] off_mask;
        logic [63:0] sum;
        rom_mask = (64'd1 << rom_aw) - 64'd1;
        off_mask = (64'd1 << bank_log2) - 64'd1;
        sum      = ((64'(bank) << bank_log2) + (64'(offset) & off_mask)) & rom_mask;
        return (sum + rom_offs) & rom_mask;
    endfunction

endpackage

// File: rtl/nmk112_region_decode.sv
// Picks which of a chip's four bank registers serves an OKI sample address.
module nmk112_region_decode
    import nmk112_pkg::*;
(
    input  logic        page_en,
    input  logic [17:0] addr,
    output logic [1:0]  bank_idx,
    output logic [15:0] offset
);

    region_e region;

    always_comb begin
        region = BANKED;
        if (page_en && addr <= TABLE_PAGE_MAX) begin
            region = TABLE_PAGE;
        end else if (page_en && addr >= TABLE_HI_MIN && addr < BANKED_MIN) begin
            region = TABLE_HI;
        end
    end

    // Phrase table pages are 0x100 bytes, so A[9:8] selects the page bank.
    always_comb begin
        bank_idx = addr[17:16];
        case (region)
            TABLE_PAGE: bank_idx = addr[9:8];
            TABLE_HI:   bank_idx = 2'd0;
            default:    bank_idx = addr[17:16];
        endcase
    end

    assign offset = addr[15:0];

endmodule

// File: rtl/nmk112_bank_mapper.sv
// NMK112 bank switch: per-chip bank registers and a 2-stage address translation pipe.
module nmk112_bank_mapper
    import nmk112_pkg::*;
#(
    parameter int          NUM_CHIPS     = 2,
    parameter int          BANK_BITS     = 8,
    parameter int          BANKSIZE_LOG2 = 16,
    parameter int          ROM_AW        = 21,
    parameter logic [3:0]  PAGE_MASK     = 4'b0011,
    parameter int unsigned ROM_OFFS      = 0,
    localparam int         CW            = clog2_min1(NUM_CHIPS)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 WR,
    input  logic [CW+1:0]        WR_OFFSET,
    input  logic [BANK_BITS-1:0] WR_DATA,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [CW-1:0]        REQ_CHIP,
    input  logic [17:0]          REQ_ADDR,
    output logic                 ROM_VALID,
    input  logic                 ROM_READY,
    output logic [ROM_AW-1:0]    ROM_ADDR,
    output logic [CW-1:0]        ROM_CHIP
);

    logic [BANK_BITS-1:0] bank_q [NUM_CHIPS][4];

    logic [CW-1:0]        wr_chip;
    logic [1:0]           wr_bank;
    logic                 wr_chip_ok;
    logic                 req_chip_ok;
    logic                 page_en;
    logic [1:0]           dec_idx;
    logic [15:0]          dec_offset;
    logic [BANK_BITS-1:0] sel_bank;

    logic                 s1_valid;
    logic [CW-1:0]        s1_chip;
    logic [15:0]          s1_offset;
    logic [BANK_BITS-1:0] s1_bank;

    logic                 s2_adv;
    logic                 s1_adv;
    logic                 accept;

    assign wr_chip     = WR_OFFSET[CW+1:2];
    assign wr_bank     = WR_OFFSET[1:0];
    assign wr_chip_ok  = int'(wr_chip) < NUM_CHIPS;
    assign req_chip_ok = int'(REQ_CHIP) < NUM_CHIPS;
    assign page_en     = PAGE_MASK[2'(REQ_CHIP)];

    nmk112_region_decode u_decode (
        .page_en  (page_en),
        .addr     (REQ_ADDR),
        .bank_idx (dec_idx),
        .offset   (dec_offset)
    );

    always_comb begin
        sel_bank = '0;
        if (req_chip_ok) begin
            sel_bank = bank_q[REQ_CHIP][dec_idx];
        end
    end

    assign s2_adv    = !ROM_VALID || ROM_READY;
    assign s1_adv    = s1_valid && s2_adv;
    assign REQ_READY = !s1_valid || s2_adv;
    assign accept    = REQ_VALID && REQ_READY;

    // Stage 1 snapshots the bank before any same-cycle write lands.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int c = 0; c < NUM_CHIPS; c++) begin
                for (int b = 0; b < 4; b++) begin
                    bank_q[c][b] <= '0;
                end
            end
        end else if (WR && wr_chip_ok) begin
            bank_q[wr_chip][wr_bank] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_valid  <= 1'b0;
            s1_chip   <= '0;
            s1_offset <= '0;
            s1_bank   <= '0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_chip   <= REQ_CHIP;
            s1_offset <= dec_offset;
            s1_bank   <= sel_bank;
        end else if (s1_adv) begin
            s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ROM_VALID <= 1'b0;
            ROM_ADDR  <= '0;
            ROM_CHIP  <= '0;
        end else if (s1_adv) begin
            ROM_VALID <= 1'b1;
            ROM_CHIP  <= s1_chip;
            ROM_ADDR  <= ROM_AW'(wrap_rom_addr(32'(s1_bank), 32'(s1_offset),
                                               BANKSIZE_LOG2, ROM_AW, 64'(ROM_OFFS)));
        end else if (ROM_READY) begin
            ROM_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nmk112_bank_mapper.sv
// Directed bench: three mapper instances (default, chip 1 unpaged, ROM offset) share one stimulus.
module tb_nmk112_bank_mapper;

    logic        clk;
    logic        reset;
    logic        wr;
    logic [2:0]  wr_offset;
    logic [7:0]  wr_data;
    logic        req_valid;
    logic [0:0]  req_chip;
    logic [17:0] req_addr;
    logic        rom_ready;

    logic        req_ready_a, req_ready_b, req_ready_c;
    logic        rom_valid_a, rom_valid_b, rom_valid_c;
    logic [20:0] rom_addr_a, rom_addr_b, rom_addr_c;
    logic [0:0]  rom_chip_a, rom_chip_b, rom_chip_c;

    int checks;
    int failures;

    logic [20:0] ga, gb, gc;
    logic [0:0]  gchip;
    int          lat;

    nmk112_bank_mapper dut_a (
        .CLK(clk), .RESET(reset), .WR(wr), .WR_OFFSET(wr_offset), .WR_DATA(wr_data),
        .REQ_VALID(req_valid), .REQ_READY(req_ready_a), .REQ_CHIP(req_chip), .REQ_ADDR(req_addr),
        .ROM_VALID(rom_valid_a), .ROM_READY(rom_ready), .ROM_ADDR(rom_addr_a), .ROM_CHIP(rom_chip_a)
    );

    nmk112_bank_mapper #(.PAGE_MASK(4'b0001)) dut_b (
        .CLK(clk), .RESET(reset), .WR(wr), .WR_OFFSET(wr_offset), .WR_DATA(wr_data),
        .REQ_VALID(req_valid), .REQ_READY(req_ready_b), .REQ_CHIP(req_chip), .REQ_ADDR(req_addr),
        .ROM_VALID(rom_valid_b), .ROM_READY(rom_ready), .ROM_ADDR(rom_addr_b), .ROM_CHIP(rom_chip_b)
    );

    nmk112_bank_mapper #(.ROM_OFFS(32'h1F0000)) dut_c (
        .CLK(clk), .RESET(reset), .WR(wr), .WR_OFFSET(wr_offset), .WR_DATA(wr_data),
        .REQ_VALID(req_valid), .REQ_READY(req_ready_c), .REQ_CHIP(req_chip), .REQ_ADDR(req_addr),
        .ROM_VALID(rom_valid_c), .ROM_READY(rom_ready), .ROM_ADDR(rom_addr_c), .ROM_CHIP(rom_chip_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bank(input logic [2:0] offs, input logic [7:0] data);
        wr        = 1'b1;
        wr_offset = offs;
        wr_data   = data;
        tick();
        wr        = 1'b0;
    endtask

    // Issues one request and waits (bounded) for its result; lat counts edges from accept.
    task automatic do_req(input logic [0:0] chip, input logic [17:0] addr,
                          output logic [20:0] oa, output logic [20:0] ob,
                          output logic [20:0] oc, output logic [0:0] ochip, output int olat);
        int n;
        req_valid = 1'b1;
        req_chip  = chip;
        req_addr  = addr;
        n = 0;
        while (!req_ready_a && n < 20) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
        olat = 1;
        while (!rom_valid_a && olat < 20) begin
            tick();
            olat++;
        end
        oa    = rom_addr_a;
        ob    = rom_addr_b;
        oc    = rom_addr_c;
        ochip = rom_chip_a;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (rom_valid_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", rom_valid_a); end
        checks++;
        if (rom_addr_a !== 21'h0) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=000000", rom_addr_a); end
        checks++;
        if (rom_chip_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_chip got=%b exp=0", rom_chip_a); end
        checks++;
        if (req_ready_a !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", req_ready_a); end
    endtask

    task automatic test_page_mode();
        write_bank(3'd1, 8'h03);
        do_req(1'b0, 18'h00150, ga, gb, gc, gchip, lat);
        checks++;
        if (ga !== 21'h030150) begin failures++; $display("[TB] FAIL page_150 got=%h exp=030150", ga); end
        checks++;
        if (lat !== 2) begin failures++; $display("[TB] FAIL latency got=%0d exp=2", lat); end
        do_req(1'b0, 18'h12345, ga, gb, gc, gchip, lat);
        checks++;
        if (ga !== 21'h032345) begin failures++; $display("[TB] FAIL page_12345 got=%h exp=032345", ga); end
        do_req(1'b0, 18'h003FF, ga, gb, gc, gchip, lat);
        checks++;
        if (ga !== 21'h0003FF) begin failures++; $display("[TB] FAIL page_3ff got=%h exp=0003ff", ga); end
    endtask

    task automatic test_table_hi();
        write_bank(3'd0, 8'h05);
        do_req(1'b0, 18'h00800, ga, gb, gc, gchip, lat);
        checks++;
        if (ga !== 21'h050800) begin failures++; $display("[TB] FAIL hi_800 got=%h exp=050800", ga); end
        checks++;
        if (gc !== 21'h040800) begin failures++; $display("[TB] FAIL hi_800_offs got=%h exp=040800", gc); end
        do_req(1'b0, 18'h00400, ga, gb, gc, gchip, lat);
        checks++;
        if (ga !== 21'h050400) begin failures++; $display("[TB] FAIL hi_400 got=%h exp=050400", ga); end
        do_req(1'b0, 18'h0FFFF, ga, gb, gc, gchip, lat);
        checks++;
        if (ga !== 21'h05FFFF) begin failures++; $display("[TB] FAIL hi_ffff got=%h exp=05ffff", ga); end
        do_req(1'b0, 18'h20010, ga, gb, gc, gchip, lat);
        checks++;
        if (ga !== 21'h000010) begin failures++; $display("[TB] FAIL banked_20010 got=%h exp=000010", ga); end
    endtask

    task automatic test_non_page();
        write_bank(3'd6, 8'h0A);
        write_bank(3'd5, 8'h0C);
        do_req(1'b1, 18'h20010, ga, gb, gc, gchip, lat);
        checks++;
        if (gb !== 21'h0A0010) begin failures++; $display("[TB] FAIL nopage_20010 got=%h exp=0a0010", gb); end
        checks++;
        if (gchip !== 1'b1) begin failures++; $display("[TB] FAIL nopage_chip got=%b exp=1", gchip); end
        do_req(1'b1, 18'h00150, ga, gb, gc, gchip, lat);
        checks++;
        if (gb !== 21'h000150) begin failures++; $display("[TB] FAIL nopage_150 got=%h exp=000150", gb); end
        checks++;
        if (ga !== 21'h0C0150) begin failures++; $display("[TB] FAIL page1_150 got=%h exp=0c0150", ga); end
    endtask

    task automatic test_wrap();
        write_bank(3'd3, 8'h25);
        do_req(1'b0, 18'h3FFFF, ga, gb, gc, gchip, lat);
        checks++;
        if (ga !== 21'h05FFFF) begin failures++; $display("[TB] FAIL wrap_3ffff got=%h exp=05ffff", ga); end
        do_req(1'b0, 18'h30010, ga, gb, gc, gchip, lat);
        checks++;
        if (ga !== 21'h050010) begin failures++; $display("[TB] FAIL wrap_30010 got=%h exp=050010", ga); end
        checks++;
        if (gc !== 21'h040010) begin failures++; $display("[TB] FAIL wrap_offs got=%h exp=040010", gc); end
    endtask

    task automatic test_back_to_back();
        tick();
        rom_ready = 1'b0;
        req_valid = 1'b1;
        req_chip  = 1'b0;
        req_addr  = 18'h00100;
        tick();
        req_addr  = 18'h00200;
        checks++;
        if (req_ready_a !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready2 got=%b exp=1", req_ready_a); end
        tick();
        req_addr  = 18'h00300;
        checks++;
        if (req_ready_a !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready3 got=%b exp=0", req_ready_a); end
        checks++;
        if (rom_valid_a !== 1'b1 || rom_addr_a !== 21'h030100) begin
            failures++; $display("[TB] FAIL bp_head got=%b/%h exp=1/030100", rom_valid_a, rom_addr_a);
        end
        repeat (3) tick();
        checks++;
        if (rom_valid_a !== 1'b1 || rom_addr_a !== 21'h030100 || req_ready_a !== 1'b0) begin
            failures++; $display("[TB] FAIL bp_hold got=%b/%h/%b exp=1/030100/0", rom_valid_a, rom_addr_a, req_ready_a);
        end
        rom_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++;
        if (rom_valid_a !== 1'b1 || rom_addr_a !== 21'h000200) begin
            failures++; $display("[TB] FAIL bp_second got=%b/%h exp=1/000200", rom_valid_a, rom_addr_a);
        end
        tick();
        checks++;
        if (rom_valid_a !== 1'b1 || rom_addr_a !== 21'h050300) begin
            failures++; $display("[TB] FAIL bp_third got=%b/%h exp=1/050300", rom_valid_a, rom_addr_a);
        end
        tick();
        checks++;
        if (rom_valid_a !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain got=%b exp=0", rom_valid_a); end
    endtask

    task automatic test_collision();
        wr        = 1'b1;
        wr_offset = 3'd1;
        wr_data   = 8'h07;
        req_valid = 1'b1;
        req_chip  = 1'b0;
        req_addr  = 18'h10000;
        tick();
        wr = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++;
        if (rom_valid_a !== 1'b1 || rom_addr_a !== 21'h030000) begin
            failures++; $display("[TB] FAIL coll_old got=%b/%h exp=1/030000", rom_valid_a, rom_addr_a);
        end
        tick();
        checks++;
        if (rom_valid_a !== 1'b1 || rom_addr_a !== 21'h070000) begin
            failures++; $display("[TB] FAIL coll_new got=%b/%h exp=1/070000", rom_valid_a, rom_addr_a);
        end
        tick();
    endtask

    task automatic test_reset_flush();
        rom_ready = 1'b0;
        req_valid = 1'b1;
        req_chip  = 1'b0;
        req_addr  = 18'h10000;
        tick();
        req_valid = 1'b0;
        tick();
        checks++;
        if (rom_valid_a !== 1'b1 || rom_addr_a !== 21'h070000) begin
            failures++; $display("[TB] FAIL flush_pre got=%b/%h exp=1/070000", rom_valid_a, rom_addr_a);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rom_valid_a !== 1'b0 || rom_addr_a !== 21'h0) begin
            failures++; $display("[TB] FAIL flush_async got=%b/%h exp=0/000000", rom_valid_a, rom_addr_a);
        end
        tick();
        reset = 1'b0;
        rom_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if (rom_valid_a !== 1'b0) begin failures++; $display("[TB] FAIL flush_replay got=%b exp=0", rom_valid_a); end
        do_req(1'b0, 18'h10000, ga, gb, gc, gchip, lat);
        checks++;
        if (ga !== 21'h000000 || lat !== 2) begin
            failures++; $display("[TB] FAIL flush_bank0 got=%h/%0d exp=000000/2", ga, lat);
        end
        do_req(1'b1, 18'h20010, ga, gb, gc, gchip, lat);
        checks++;
        if (gb !== 21'h000010) begin failures++; $display("[TB] FAIL flush_bank1 got=%h exp=000010", gb); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        wr        = 1'b0;
        wr_offset = '0;
        wr_data   = '0;
        req_valid = 1'b0;
        req_chip  = '0;
        req_addr  = '0;
        rom_ready = 1'b1;
        test_reset();
        test_page_mode();
        test_table_hi();
        test_non_page();
        test_wrap();
        test_back_to_back();
        test_collision();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
